// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multicycle MIPS control FSM
package mcctl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] IMM_SEXT  = 2'b00;
  localparam logic [1:0] IMM_ZEXT  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       iord;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] immtype;
    logic [2:0] alu;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction-register/datapath/memory bundle around the controller
interface multicycle_controller_if #(parameter int ALUCTL_W = 3);
  import mcctl_pkg::*;

  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                memwrite;
  logic                irwrite;
  logic                iord;
  logic                pcen;
  logic                regwrite;
  logic                regdst;
  logic                memtoreg;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [1:0]          pcsrc;
  logic [1:0]          immtype;
  logic [ALUCTL_W-1:0] alucontrol;
  logic                illegal;
  logic [STATE_W-1:0]  state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, irwrite, iord, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, immtype, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, irwrite, iord, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, immtype, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// rtl/multicycle_controller_aludec.sv - R-type funct to ALU control decode with legality flag
module mc_aludec
  import mcctl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_legal
);

  always_comb begin
    alucontrol  = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      F_ADD:   alucontrol = ALU_ADD;
      F_SUB:   alucontrol = ALU_SUB;
      F_AND:   alucontrol = ALU_AND;
      F_OR:    alucontrol = ALU_OR;
      F_SLT:   alucontrol = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM sequencing multicycle MIPS instructions
module multicycle_controller
  import mcctl_pkg::*;
#(
  parameter int BNE_EN   = 1,
  parameter int WAIT_EN  = 1,
  parameter int ALUCTL_W = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  multicycle_controller_if.master  bus
);

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic       rdy;
  logic [2:0] rt_alu;
  logic       funct_legal;

  assign rdy = bus.mem_ready | (WAIT_EN == 0);

  mc_aludec u_aludec (
    .funct       (bus.funct),
    .alucontrol  (rt_alu),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.alu     = ALU_ADD;
        ctrl.irwrite = rdy;
        ctrl.pcen    = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.alu     = ALU_ADD;
        case (bus.op)
          OP_RTYPE:              state_d = funct_legal ? S_RTEXEC : S_ILLEGAL;
          OP_LW, OP_SW:          state_d = S_MEMADR;
          OP_BEQ:                state_d = S_BRANCH;
          OP_BNE:                state_d = (BNE_EN != 0) ? S_BRANCH : S_ILLEGAL;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.immtype = IMM_SEXT;
        ctrl.alu     = ALU_ADD;
        state_d      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_RTEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alu     = rt_alu;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        // op[0] separates BNE (000101) from BEQ (000100)
        ctrl.alusrca = 1'b1;
        ctrl.alu     = ALU_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.pcen    = bus.op[0] ? ~bus.zero : bus.zero;
        state_d      = S_FETCH;
      end
      S_IEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        case (bus.op)
          OP_ORI:  begin ctrl.immtype = IMM_ZEXT;  ctrl.alu = ALU_OR;  end
          OP_LUI:  begin ctrl.immtype = IMM_UPPER; ctrl.alu = ALU_OR;  end
          default: begin ctrl.immtype = IMM_SEXT;  ctrl.alu = ALU_ADD; end
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pcen  = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        ctrl.illegal = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // strobes must drop the instant reset asserts, not at the next edge
    if (!reset_n) ctrl = '0;
  end

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.iord       = ctrl.iord;
  assign bus.pcen       = ctrl.pcen;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.immtype    = ctrl.immtype;
  assign bus.alucontrol = ALUCTL_W'(ctrl.alu);
  assign bus.illegal    = ctrl.illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed per-cycle vector bench for multicycle_controller
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic watch = 1'b0;
  logic rw_seen = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller_if #(.ALUCTL_W(3)) bus ();
  multicycle_controller_if #(.ALUCTL_W(3)) bus_nb ();

  multicycle_controller #(.BNE_EN(1), .WAIT_EN(1), .ALUCTL_W(3)) dut (
    .clk (clk), .reset_n (reset_n), .bus (bus.master));
  multicycle_controller #(.BNE_EN(0), .WAIT_EN(1), .ALUCTL_W(3)) dut_nb (
    .clk (clk), .reset_n (reset_n), .bus (bus_nb.master));

  assign bus_nb.op        = bus.op;
  assign bus_nb.funct     = bus.funct;
  assign bus_nb.zero      = bus.zero;
  assign bus_nb.mem_ready = bus.mem_ready;

  logic [18:0] act, act_nb;
  assign act = {bus.mem_req, bus.memwrite, bus.irwrite, bus.iord, bus.pcen, bus.regwrite,
                bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.immtype,
                bus.alucontrol, bus.illegal};
  assign act_nb = {bus_nb.mem_req, bus_nb.memwrite, bus_nb.irwrite, bus_nb.iord, bus_nb.pcen,
                   bus_nb.regwrite, bus_nb.regdst, bus_nb.memtoreg, bus_nb.alusrca,
                   bus_nb.alusrcb, bus_nb.pcsrc, bus_nb.immtype, bus_nb.alucontrol,
                   bus_nb.illegal};

  always @(posedge clk) if (watch && bus.regwrite) rw_seen <= 1'b1;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] o;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [18:0] pk(input logic mreq, mw, ir, iord, pcen, rw, rd, mtr, asa,
                                     input logic [1:0] asb, pcs, imm,
                                     input logic [2:0] alu, input logic ill);
    return {mreq, mw, ir, iord, pcen, rw, rd, mtr, asa, asb, pcs, imm, alu, ill};
  endfunction

  function automatic logic [18:0] o_fetch(input logic r);
    return pk(1, 0, r, 0, r, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [18:0] o_rt(input logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, alu, 0);
  endfunction
  function automatic logic [18:0] o_br(input logic p);
    return pk(0, 0, 0, 0, p, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 3'b110, 0);
  endfunction
  function automatic logic [18:0] o_ie(input logic [1:0] imm, input logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, imm, alu, 0);
  endfunction

  localparam logic [18:0] O_DEC  = {9'b0, 2'b11, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [18:0] O_MADR = {8'b0, 1'b1, 2'b10, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [18:0] O_MRD  = {4'b1001, 15'b0};
  localparam logic [18:0] O_MWB  = {8'b00000101, 11'b0};
  localparam logic [18:0] O_MWR  = {4'b1101, 15'b0};
  localparam logic [18:0] O_AWB  = {8'b00000110, 11'b0};
  localparam logic [18:0] O_IWB  = {8'b00000100, 11'b0};
  localparam logic [18:0] O_JMP  = {4'b0000, 1'b1, 6'b0, 2'b10, 6'b0};
  localparam logic [18:0] O_ILL  = 19'd1;

  task automatic add(input logic [5:0] op, f, input logic z, r, input logic [3:0] st,
                     input logic [18:0] o);
    vec_t v;
    v.op = op; v.funct = f; v.zero = z; v.rdy = r; v.st = st; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build;
    logic [5:0] rf [5];
    logic [2:0] ra [5];
    rf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    ra = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    // LW with two stall cycles in MEMRD
    add(6'h23, 0, 0, 1, 0, o_fetch(1)); add(6'h23, 0, 0, 1, 1, O_DEC);
    add(6'h23, 0, 0, 1, 2, O_MADR);     add(6'h23, 0, 0, 0, 3, O_MRD);
    add(6'h23, 0, 0, 0, 3, O_MRD);      add(6'h23, 0, 0, 1, 3, O_MRD);
    add(6'h23, 0, 0, 1, 4, O_MWB);
    // SW without and with a stall
    add(6'h2B, 0, 0, 1, 0, o_fetch(1)); add(6'h2B, 0, 0, 1, 1, O_DEC);
    add(6'h2B, 0, 0, 1, 2, O_MADR);     add(6'h2B, 0, 0, 1, 5, O_MWR);
    add(6'h2B, 0, 0, 1, 0, o_fetch(1)); add(6'h2B, 0, 0, 1, 1, O_DEC);
    add(6'h2B, 0, 0, 1, 2, O_MADR);     add(6'h2B, 0, 0, 0, 5, O_MWR);
    add(6'h2B, 0, 0, 1, 5, O_MWR);
    // J with a stalled fetch
    add(6'h02, 0, 0, 0, 0, o_fetch(0)); add(6'h02, 0, 0, 1, 0, o_fetch(1));
    add(6'h02, 0, 0, 1, 1, O_DEC);      add(6'h02, 0, 0, 1, 11, O_JMP);
    // BEQ/BNE with both zero values
    for (int k = 0; k < 4; k++) begin
      logic [5:0] bop;
      logic       z;
      bop = (k < 2) ? 6'h04 : 6'h05;
      z   = k[0];
      add(bop, 0, z, 1, 0, o_fetch(1)); add(bop, 0, z, 1, 1, O_DEC);
      add(bop, 0, z, 1, 8, o_br((k < 2) ? z : ~z));
    end
    for (int k = 0; k < 5; k++) begin
      add(0, rf[k], 0, 1, 0, o_fetch(1)); add(0, rf[k], 0, 1, 1, O_DEC);
      add(0, rf[k], 0, 1, 6, o_rt(ra[k])); add(0, rf[k], 0, 1, 7, O_AWB);
    end
    add(0, 6'h3F, 0, 1, 0, o_fetch(1)); add(0, 6'h3F, 0, 1, 1, O_DEC);
    add(0, 6'h3F, 0, 1, 12, O_ILL);
    add(6'h0D, 0, 0, 1, 0, o_fetch(1)); add(6'h0D, 0, 0, 1, 1, O_DEC);
    add(6'h0D, 0, 0, 1, 9, o_ie(2'b01, 3'b001)); add(6'h0D, 0, 0, 1, 10, O_IWB);
    add(6'h0F, 0, 0, 1, 0, o_fetch(1)); add(6'h0F, 0, 0, 1, 1, O_DEC);
    add(6'h0F, 0, 0, 1, 9, o_ie(2'b10, 3'b001)); add(6'h0F, 0, 0, 1, 10, O_IWB);
    add(6'h08, 0, 0, 1, 0, o_fetch(1)); add(6'h08, 0, 0, 1, 1, O_DEC);
    add(6'h08, 0, 0, 1, 9, o_ie(2'b00, 3'b010)); add(6'h08, 0, 0, 1, 10, O_IWB);
    add(6'h3F, 0, 0, 1, 0, o_fetch(1)); add(6'h3F, 0, 0, 1, 1, O_DEC);
    add(6'h3F, 0, 0, 1, 12, O_ILL);
  endtask

  initial begin
    build();
    reset_n = 1'b0;
    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_outputs", 32'(act), 0);
    chk("reset_state", 32'(bus.state), 0);
    chk("reset_outputs_nb", 32'(act_nb), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      bus.op = vecs[i].op; bus.funct = vecs[i].funct;
      bus.zero = vecs[i].zero; bus.mem_ready = vecs[i].rdy;
      #2;
      chk($sformatf("state[%0d]", i), 32'(bus.state), 32'(vecs[i].st));
      chk($sformatf("outputs[%0d]", i), 32'(act), 32'(vecs[i].o));
      @(posedge clk);
      #1;
    end

    // BNE decodes as illegal when BNE_EN=0
    bus.op = 6'h05; bus.funct = 0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    tick(); tick();
    chk("bne_en0_state", 32'(bus_nb.state), 12);
    chk("bne_en0_illegal", 32'(bus_nb.illegal), 1);
    chk("bne_en1_state", 32'(bus.state), 8);
    tick();
    chk("bne_en0_back_fetch", 32'(bus_nb.state), 0);

    // reset asserted mid-IEXEC must abort the ADDI before write-back
    bus.op = 6'h08;
    tick(); tick();
    chk("iexec_reached", 32'(bus.state), 9);
    watch = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(act), 0);
    chk("async_reset_state", 32'(bus.state), 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_reset_state", 32'(bus.state), 0);
    chk("post_reset_outputs", 32'(act), 32'(o_fetch(1)));
    tick();
    chk("post_reset_decode", 32'(bus.state), 1);
    tick();
    chk("post_reset_no_regwrite", 32'(rw_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM for the multicycle MIPS datapath. It replaces single-cycle decode by sequencing each instruction over 3-5 states.
- Memory is a shared instruction/data memory with a ready handshake, so fetch, load and store can stall.
- Adds BNE, an illegal-instruction pulse and an exposed state for debug. Sits between the instruction register (op/funct) and the multicycle datapath.

Parameters:
- BNE_EN, 1: decode op 000101 (BNE); when 0, BNE is illegal.
- WAIT_EN, 1: honour mem_ready; when 0, mem_ready is treated as constant 1.
- ALUCTL_W, 3: width of alucontrol; codes are zero-extended when wider.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  opcode from instruction register, stable from DECODE to end of instruction
- funct  in  6  function field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- iord  out  1  address select: 0=PC, 1=ALUOut
- pcen  out  1  PC load enable
- regwrite  out  1  register file write
- regdst  out  1  1=rd, 0=rt
- memtoreg  out  1  1=Data register, 0=ALUOut
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=imm, 11=imm<<2
- pcsrc  out  2  00=ALU, 01=ALUOut, 10=jump target
- immtype  out  2  00=sign-ext, 01=zero-ext, 10=upper (imm<<16)
- alucontrol  out  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse on undecodable instruction
- state  out  4  current state (debug)

Behaviour:
- Single clock clk. reset_n is asynchronous and active-low. While reset_n=0: state=FETCH and every output is forced to 0.
- Outputs are combinational from state, plus op/funct/zero/mem_ready where listed below. Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, ILLEGAL 12. Codes 13-15 go to FETCH.
- rdy = mem_ready | ~WAIT_EN.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite=pcen=rdy.
  - Stay while ~rdy; otherwise go to DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, add.
  - Next state by op:
    - 000000 with a legal funct -> RTEXEC.
    - 100011 or 101011 -> MEMADR.
    - 000100, or 000101 when BNE_EN -> BRANCH.
    - 001000, 001101, 001111 -> IEXEC.
    - 000010 -> JUMP.
    - Anything else, or R-type with funct not in {100000, 100010, 100100, 100101, 101010} -> ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, immtype=00, add. Go to MEMRD if op=100011, else MEMWR.
- MEMRD: mem_req=1, iord=1. Stay while ~rdy; otherwise go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, held until rdy. On rdy go to FETCH.
- RTEXEC: alusrca=1, alusrcb=00, alucontrol from funct. Go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for BEQ, ~zero for BNE (selected by op[0]).
  - Go to FETCH.
- IEXEC: alusrca=1, alusrcb=10.
  - ADDI: immtype=00, add.
  - ORI: immtype=01, or.
  - LUI: immtype=10, or.
  - Go to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
- JUMP: pcsrc=10, pcen=1. Go to FETCH.
- ILLEGAL: illegal=1, no architectural writes. Go to FETCH; the PC has already advanced, so the instruction is skipped.
- Latency with no wait states, in cycles: R-type 4, LW 5, SW 4, BEQ/BNE 3, I-type ALU 4, J 3, illegal 3. Each stall cycle adds 1.
- Reset asserted mid-instruction: the FSM aborts immediately and all strobes drop asynchronously. No partial write is issued after reset_n rises.

Decomposition:
- Package mcctl_pkg: state encodings, STATE_W=4, opcode constants, funct constants, alucontrol codes, immtype codes.
- One sub-module, mc_aludec (combinational): maps funct to alucontrol and produces a funct_legal flag.

Test Plan:
- Reset: hold reset_n=0 then release, mem_ready=1 -> all outputs 0 during reset. First cycle: state=0, mem_req=1, irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- LW (op 0x23) with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. regwrite=1 and memtoreg=1 only in state 4.
- SW (op 0x2B), mem_ready=1 -> states 0,1,2,5,0. memwrite=1 exactly one cycle, iord=1.
- BEQ with zero=1 gives pcen=1 and pcsrc=01 in BRANCH. BNE with zero=1 gives pcen=0. BNE with BNE_EN=0 -> illegal=1 in state 12.
- R-type funct 0x2A -> alucontrol=111 in RTEXEC and regdst=1 in ALUWB. Funct 0x3F -> ILLEGAL pulse, regwrite never asserted.
- ORI/LUI/ADDI -> immtype 01/10/00 with alucontrol 001/001/010 in IEXEC. Assert reset_n=0 during IEXEC -> the next state after release is FETCH and regwrite never asserts.
